// File: rtl/int_res_mem_reader_pkg.sv
// Shared intermediate-result storage types and constants for the CIM.
// Holds the memory-map constants, address/data types, the width selector
// and the read-port FSM state type.
package int_res_mem_reader_pkg;

  localparam int unsigned CIM_INT_RES_NUM_BANKS          = 4;
  localparam int unsigned CIM_INT_RES_BANK_SIZE_NUM_WORD = 14336;
  localparam int unsigned N_STO_INT_RES                  = 9;
  localparam int unsigned CIM_INT_RES_ADDR_W             = 16;
  localparam int unsigned CIM_INT_RES_BANK_ADDR_W        = $clog2(CIM_INT_RES_BANK_SIZE_NUM_WORD);

  typedef logic [CIM_INT_RES_ADDR_W-1:0]      IntResAddr_t;
  typedef logic [CIM_INT_RES_BANK_ADDR_W-1:0] IntResBankAddr_t;
  typedef logic [N_STO_INT_RES-1:0]           IntResSingle_t;
  typedef logic [2*N_STO_INT_RES-1:0]         IntResDouble_t;

  typedef enum logic {
    SINGLE_WIDTH = 1'b0,
    DOUBLE_WIDTH = 1'b1
  } DataWidth_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_FIRST  = 2'd1,
    RD_SECOND = 2'd2,
    CAPTURE   = 2'd3
  } IntResRdState_t;

endpackage

// File: rtl/int_res_mem_reader_if.sv
// Bundle of the request, bank-access and response signals of the
// intermediate-result read port. slave = reader side, master = the
// requester/consumer/bank side.
interface int_res_mem_reader_if
  import int_res_mem_reader_pkg::*;
#(
  parameter int unsigned NUM_BANKS = CIM_INT_RES_NUM_BANKS,
  parameter int unsigned N_STO     = N_STO_INT_RES
);

  logic                            req_valid;
  logic                            req_ready;
  IntResAddr_t                     req_addr;
  DataWidth_t                      req_width;
  logic [NUM_BANKS-1:0]            bank_en;
  IntResBankAddr_t                 bank_addr;
  logic [NUM_BANKS-1:0][N_STO-1:0] bank_rdata;
  logic                            rsp_valid;
  logic [2*N_STO-1:0]              rsp_data;
  logic                            rsp_err;

  modport slave (
    input  req_valid, req_addr, req_width, bank_rdata,
    output req_ready, bank_en, bank_addr, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_width, bank_rdata,
    input  req_ready, bank_en, bank_addr, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/int_res_mem_reader_addr_decode.sv
// Flat intermediate-result address -> {bank one-hot, in-bank offset,
// out-of-range}. Purely combinational; banks are contiguous ranges of
// BANK_DEPTH words.
module int_res_addr_decode
  import int_res_mem_reader_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = CIM_INT_RES_NUM_BANKS,
  parameter int unsigned BANK_DEPTH = CIM_INT_RES_BANK_SIZE_NUM_WORD
) (
  input  IntResAddr_t          addr_i,
  output logic [NUM_BANKS-1:0] bank_onehot_o,
  output IntResBankAddr_t      offset_o,
  output logic                 out_of_range_o
);

  logic [31:0] addr_w;

  assign addr_w = 32'(addr_i);

  // Range compare per bank instead of a divider; at most one bank matches.
  always_comb begin
    bank_onehot_o  = '0;
    offset_o       = '0;
    out_of_range_o = (addr_w >= 32'(NUM_BANKS * BANK_DEPTH));
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if ((addr_w >= 32'(b * BANK_DEPTH)) && (addr_w < 32'((b + 1) * BANK_DEPTH))) begin
        bank_onehot_o[b] = 1'b1;
        offset_o         = IntResBankAddr_t'(addr_w - 32'(b * BANK_DEPTH));
      end
    end
  end

endmodule

// File: rtl/int_res_mem_reader.sv
// Intermediate-result read port: accepts single/double-width reads on the
// flat address space, sequences one or two bank reads and returns a
// sign-extended (single) or packed {hi,lo} (double) result.
// Optional: INT_RES_RD_ALIGN_CHECK_EN rejects odd double-width addresses.
module int_res_mem_reader
  import int_res_mem_reader_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = CIM_INT_RES_NUM_BANKS,
  parameter int unsigned BANK_DEPTH = CIM_INT_RES_BANK_SIZE_NUM_WORD,
  parameter int unsigned N_STO      = N_STO_INT_RES
) (
  input logic                  clk,
  input logic                  rst,
  int_res_mem_reader_if.slave  bus
);

  IntResRdState_t       state_q, state_d;
  IntResAddr_t          addr_q;
  DataWidth_t           width_q;
  logic                 err_q;
  logic [NUM_BANKS-1:0] bank_en_q, bank_en_d;
  IntResBankAddr_t      bank_addr_q, bank_addr_d;
  logic [NUM_BANKS-1:0] rd_sel_q;
  logic [N_STO-1:0]     hi_q, hi_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [2*N_STO-1:0]   rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 accept;
  logic                 req_err;
  IntResAddr_t          dec_addr, dec_addr_p1;
  logic [NUM_BANKS-1:0] hi_onehot, lo_onehot;
  IntResBankAddr_t      hi_off, lo_off;
  logic                 hi_oor, lo_oor;
  logic [N_STO-1:0]     rd_word;

  assign accept = bus.req_valid && (state_q == IDLE);

  // The two decoders look at the live request while idle and at the latched
  // address afterwards, so the second word's bank is available in RD_FIRST.
  assign dec_addr    = (state_q == IDLE) ? bus.req_addr : addr_q;
  assign dec_addr_p1 = dec_addr + IntResAddr_t'(1);

  int_res_addr_decode #(
    .NUM_BANKS  (NUM_BANKS),
    .BANK_DEPTH (BANK_DEPTH)
  ) u_dec_hi (
    .addr_i         (dec_addr),
    .bank_onehot_o  (hi_onehot),
    .offset_o       (hi_off),
    .out_of_range_o (hi_oor)
  );

  int_res_addr_decode #(
    .NUM_BANKS  (NUM_BANKS),
    .BANK_DEPTH (BANK_DEPTH)
  ) u_dec_lo (
    .addr_i         (dec_addr_p1),
    .bank_onehot_o  (lo_onehot),
    .offset_o       (lo_off),
    .out_of_range_o (lo_oor)
  );

  // Rejection status of the request currently presented.
  always_comb begin
    req_err = hi_oor || ((bus.req_width == DOUBLE_WIDTH) && lo_oor);
`ifdef INT_RES_RD_ALIGN_CHECK_EN
    if ((bus.req_width == DOUBLE_WIDTH) && bus.req_addr[0]) begin
      req_err = 1'b1;
    end
`endif
  end

  // Select the word returned by whichever bank was enabled last cycle.
  always_comb begin
    rd_word = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (rd_sel_q[b]) begin
        rd_word = rd_word | bus.bank_rdata[b];
      end
    end
  end

  // Next-state and registered-output logic of the read sequencer.
  always_comb begin
    state_d     = state_q;
    bank_en_d   = '0;
    bank_addr_d = bank_addr_q;
    hi_d        = hi_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RD_FIRST;
          if (!req_err) begin
            bank_en_d   = hi_onehot;
            bank_addr_d = hi_off;
          end
        end
      end
      RD_FIRST: begin
        if (width_q == DOUBLE_WIDTH) begin
          state_d = RD_SECOND;
          if (!err_q) begin
            bank_en_d   = lo_onehot;
            bank_addr_d = lo_off;
          end
        end else begin
          state_d = CAPTURE;
        end
      end
      RD_SECOND: begin
        hi_d    = rd_word;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        if (err_q) begin
          rsp_data_d = '0;
        end else if (width_q == DOUBLE_WIDTH) begin
          rsp_data_d = {hi_q, rd_word};
        end else begin
          rsp_data_d = {{N_STO{rd_word[N_STO-1]}}, rd_word};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bank-access and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bank_en_q   <= '0;
      bank_addr_q <= '0;
      rd_sel_q    <= '0;
      hi_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_en_q   <= bank_en_d;
      bank_addr_q <= bank_addr_d;
      rd_sel_q    <= bank_en_q;
      hi_q        <= hi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Request context latched at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      width_q <= SINGLE_WIDTH;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      width_q <= bus.req_width;
      err_q   <= req_err;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.bank_en   = bank_en_q;
  assign bus.bank_addr = bank_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_int_res_mem_reader.sv
// Scoreboard bench for int_res_mem_reader: directed memory-map cases,
// mid-operation reset, then randomized reads near bank/range boundaries.
// Honors INT_RES_RD_ALIGN_CHECK_EN in the reference model.
module tb_int_res_mem_reader;
  import int_res_mem_reader_pkg::*;

  localparam int NB    = 4;
  localparam int DEPTH = 14336;
  localparam int NS    = 9;
  localparam int TOTAL = NB * DEPTH;

  typedef struct {
    int          cyc;
    logic        err;
    logic [17:0] data;
  } rsp_t;

  typedef struct {
    int cyc;
    int bank;
    int off;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  rsp_t rsp_q[$];
  acc_t acc_q[$];
  logic [NS-1:0] mem [NB][DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int_res_mem_reader_if #(.NUM_BANKS(NB), .N_STO(NS)) bus ();

  int_res_mem_reader #(
    .NUM_BANKS  (NB),
    .BANK_DEPTH (DEPTH),
    .N_STO      (NS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM banks: one-cycle read latency, garbage on disabled banks.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bus.bank_en[b] && (int'(bus.bank_addr) < DEPTH))
        bus.bank_rdata[b] <= mem[b][bus.bank_addr];
      else
        bus.bank_rdata[b] <= NS'($urandom);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: bank accesses and responses against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bank_en != '0) begin
        if (acc_q.size() == 0) begin
          check("bank_en_unexpected", 32'(bus.bank_en), 32'd0);
        end else begin
          acc_t a;
          a = acc_q.pop_front();
          check("bank_cycle", 32'(cyc), 32'(a.cyc));
          check("bank_en", 32'(bus.bank_en), 32'(1) << a.bank);
          check("bank_addr", 32'(bus.bank_addr), 32'(a.off));
        end
      end else if (acc_q.size() > 0 && acc_q[0].cyc <= cyc) begin
        acc_t a;
        a = acc_q.pop_front();
        check("bank_en_missing", 32'(bus.bank_en), 32'(1) << a.bank);
      end

      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_valid_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(r.cyc));
          check("rsp_err", 32'(bus.rsp_err), 32'(r.err));
          check("rsp_data", 32'(bus.rsp_data), 32'(r.data));
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
        void'(rsp_q.pop_front());
        check("rsp_valid_missing", 32'(bus.rsp_valid), 32'd1);
      end
    end
  end

  // Drive one request, wait (bounded) for acceptance, push expectations.
  task automatic issue(input int addr, input logic dbl);
    int   tries = 0;
    int   acc;
    logic err;
    int   lo;
    logic [NS-1:0] whi, wlo;
    rsp_t r;
    acc_t a;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr[15:0];
    bus.req_width = dbl ? DOUBLE_WIDTH : SINGLE_WIDTH;
    while (!bus.req_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    lo  = addr + 1;
    err = (addr >= TOTAL) || (dbl && lo >= TOTAL);
`ifdef INT_RES_RD_ALIGN_CHECK_EN
    if (dbl && (addr % 2 == 1)) err = 1'b1;
`endif
    r.err = err;
    r.cyc = dbl ? acc + 3 : acc + 2;
    if (err) begin
      r.data = '0;
    end else begin
      whi = mem[addr / DEPTH][addr % DEPTH];
      a.cyc = acc; a.bank = addr / DEPTH; a.off = addr % DEPTH;
      acc_q.push_back(a);
      if (dbl) begin
        wlo = mem[lo / DEPTH][lo % DEPTH];
        a.cyc = acc + 1; a.bank = lo / DEPTH; a.off = lo % DEPTH;
        acc_q.push_back(a);
        r.data = {whi, wlo};
      end else begin
        r.data = {{NS{whi[NS-1]}}, whi};
      end
    end
    rsp_q.push_back(r);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  initial begin
    int addr;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_width = SINGLE_WIDTH;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < DEPTH; i++)
        mem[b][i] = NS'($urandom);
    mem[0][14335] = 9'h1FF;
    mem[1][0]     = 9'h055;
    mem[0][100]   = 9'h0A5;
    mem[0][101]   = 9'h13C;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_bank_en", 32'(bus.bank_en), 32'd0);
    check("reset_bank_addr", 32'(bus.bank_addr), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);

    issue(14335, 1'b0);
    issue(14336, 1'b0);
    issue(100, 1'b1);
    issue(14335, 1'b1);
    issue(57344, 1'b0);
    issue(57343, 1'b1);
    repeat (6) @(negedge clk);

    // Reset while a double read is in flight.
    issue(200, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rsp_q.delete();
    acc_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_bank_en", 32'(bus.bank_en), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (5) @(negedge clk);
    issue(300, 1'b1);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: addr = int'($urandom_range(0, TOTAL - 1));
        1: addr = int'($urandom_range(1, NB)) * DEPTH - 1 + int'($urandom_range(0, 1));
        2: addr = int'($urandom_range(TOTAL - 2, TOTAL + 2));
        default: addr = int'($urandom_range(TOTAL, 65535));
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(addr, 1'($urandom_range(0, 1)));
    end

    repeat (10) @(negedge clk);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("acc_queue_drained", 32'(acc_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_res_mem_reader.md
# int_res_mem_reader

Read-side port of the intermediate-result storage in the centralized CIM. It accepts single- or double-width read requests on the flat intermediate-result address space. It decodes each request into bank and in-bank offset across the `CIM_INT_RES_NUM_BANKS` banks, sequences one or two SRAM reads, and returns a sign-extended `IntResDouble_t` to the compute datapath. It is the consumer-side counterpart of the intermediate-result write path that uses the same memory map and `DataWidth_t` packing.

## Interface
- `NUM_BANKS`, default `CIM_INT_RES_NUM_BANKS` (4): number of intermediate-result banks.
- `BANK_DEPTH`, default `CIM_INT_RES_BANK_SIZE_NUM_WORD` (14336): words per bank. Must be even.
- `N_STO`, default `N_STO_INT_RES` (9): stored word width.
- `clk`, in, 1: the only clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: a read request is present.
- `req_ready`, out, 1: the block can accept a request this cycle.
- `req_addr`, in, `IntResAddr_t` (16): flat word address.
- `req_width`, in, `DataWidth_t`: selects `SINGLE_WIDTH` or `DOUBLE_WIDTH`.
- `bank_en`, out, `NUM_BANKS`: one-hot bank read enable.
- `bank_addr`, out, `IntResBankAddr_t`: in-bank offset, shared by all banks.
- `bank_rdata`, in, `NUM_BANKS` x `N_STO`: bank read data, valid 1 cycle after `bank_en`.
- `rsp_valid`, out, 1: single-cycle response pulse. The consumer has no backpressure.
- `rsp_data`, out, `IntResDouble_t`: response data.
- `rsp_err`, out, 1: the request was rejected. Qualified by `rsp_valid`.

## Operation
- **Handshake:** a request is accepted on any edge where `req_valid && req_ready`. `req_ready` = (state == IDLE). At acceptance the block latches the address, the width and the error status.
- **Address decode:** bank = addr / `BANK_DEPTH`, offset = addr % `BANK_DEPTH`.
- **Double-width packing:** the MSB half is at `addr` and the LSB half is at `addr+1`. The second word is decoded independently and may fall in the next bank.
- **Error condition:** the request is rejected when `addr >= NUM_BANKS*BANK_DEPTH` (57344), or when the width is double and `addr+1` is out of range.
  - No `bank_en` is ever asserted for a rejected request.
  - The response arrives with normal latency, with `rsp_err=1` and `rsp_data=0`.
- **Single-width result:** `rsp_data` = `N_STO`-bit word sign-extended to 18 bits.
- **Double-width result:** `rsp_data` = {hi word, lo word}, with no extension.
- **FSM states:** IDLE, RD_FIRST, RD_SECOND, CAPTURE.
  - IDLE → RD_FIRST on accept.
  - RD_FIRST drives `bank_en`/`bank_addr` for the first word. It then goes to RD_SECOND if the width is double, else to CAPTURE.
  - RD_SECOND registers the first word into the hi register and drives the access for the second word. It then goes to CAPTURE.
  - CAPTURE registers the final word and builds `rsp_data`. It then goes to IDLE.
- **Error path:** an erroring request still walks the same states, with `bank_en` held at 0.
- `bank_en` and `bank_addr` are registered outputs. `bank_en` is all-zero outside RD_FIRST and RD_SECOND. `bank_addr` holds its last value while idle.

## Timing
- **Reset values:** state=IDLE, `req_ready`=1, `bank_en`=0, `bank_addr`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
- **Single-width timing:** accept at edge 0. `bank_en` is high in cycle 1. `rsp_valid` is high in cycle 3.
- **Double-width timing:** accept at edge 0. `bank_en` is high in cycles 1 and 2. `rsp_valid` is high in cycle 4.
- **Back-to-back throughput:** `rsp_valid` is asserted in the cycle the FSM re-enters IDLE, so a new request can be accepted that same cycle. Sustained throughput is 1 per 3 cycles (single) or 1 per 4 cycles (double).
- `rsp_valid` is exactly one cycle wide. `rsp_data` and `rsp_err` hold their values until the next response.
- **Reset mid-operation:** at the next edge the FSM returns to IDLE and `bank_en` goes to 0. The in-flight response is dropped and `rsp_valid` is never asserted for it.
- Requests presented while not ready are ignored and not queued.

## Configuration
- `INT_RES_RD_ALIGN_CHECK_EN` defined:
  - A double-width request with odd `req_addr` is rejected (`rsp_err=1`, no bank access).
  - Double-width reads therefore never cross a bank boundary.
- `INT_RES_RD_ALIGN_CHECK_EN` not defined:
  - Odd double-width addresses are legal.
  - A cross-bank pair (e.g. 14335/14336) reads the hi word from bank b and the lo word from bank b+1.

## Structure
- **Shared package:** `IntResAddr_t`, `IntResBankAddr_t`, `IntResSingle_t`, `IntResDouble_t`, `DataWidth_t` and the `CIM_INT_RES_*` constants already live there. Add `IntResRdState_t` (the FSM enum) to the same package.
- **Sub-module `int_res_addr_decode`:** combinational. Maps a flat address to {bank one-hot, offset, out_of_range}. It is instantiated twice: once for `addr` and once for `addr+1`.

## Test plan
- Single read at addr 14335, bank0[14335]=9'h1FF → `bank_en`=0001 with `bank_addr`=14335 in cycle 1; cycle 3 `rsp_data`=18'h3FFFF, `rsp_err`=0.
- Single read at addr 14336, bank1[0]=9'h055 → `bank_en`=0010 with offset 0; `rsp_data`=18'h00055.
- Double read at addr 100, bank0[100]=9'h0A5, bank0[101]=9'h13C → `rsp_data`={9'h0A5,9'h13C} in cycle 4.
- Double read at addr 14335:
  - Without the macro: hi from bank0[14335], lo from bank1[0].
  - With the macro: no `bank_en`, `rsp_err`=1, `rsp_data`=0.
- Single read at addr 57344 and double read at addr 57343 → `bank_en` stays 0 throughout; `rsp_err`=1 at normal latency.
- Double request accepted, `rst` asserted in cycle 2 → `bank_en`=0 and `req_ready`=1 the next cycle; no `rsp_valid`; the next request completes normally.
